// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a
// micro-op, registered with stall/flush control toward execute.

package riscv_uop_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [1:0]  src_a_sel;
        logic        src_b_sel;
        logic        rd_we;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        branch;
        logic [2:0]  br_funct3;
        logic        jal;
        logic        jalr;
        logic        fence;
        logic        ecall;
        logic        ebreak;
        logic        illegal;
    } uop_t;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

module decode_stage
    import riscv_uop_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_if_valid,
    input  logic [31:0] i_if_pc,
    input  logic [31:0] i_if_instr,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_dec_valid,
    output uop_t        o_uop,
    output logic [31:0] o_dec_pc,
    output logic        o_stall_to_if
);

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        f7_zero;
    logic        f7_alt;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic is_branch;
    logic is_load;
    logic is_store;
    logic is_opimm;
    logic is_op;
    logic is_misc;
    logic is_system;

    uop_t dec;
    logic bad;
    logic writes;

    assign instr   = i_if_instr;
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    // Full 7-bit compares, so a word with instr[1:0] != 2'b11 matches none
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_misc   = (opcode == OPC_MISC);
    assign is_system = (opcode == OPC_SYSTEM);

    always_comb begin
        dec     = '0;
        dec.rd  = instr[11:7];
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        bad     = 1'b0;
        writes  = 1'b0;

        unique case (1'b1)
            is_lui: begin
                dec.imm       = imm_u;
                dec.src_b_sel = 1'b1;
                dec.alu_op    = ALU_PASS_B;
                writes        = 1'b1;
            end
            is_auipc: begin
                dec.imm       = imm_u;
                dec.src_a_sel = SRC_A_PC;
                dec.src_b_sel = 1'b1;
                dec.alu_op    = ALU_ADD;
                writes        = 1'b1;
            end
            is_jal: begin
                dec.imm       = imm_j;
                dec.src_a_sel = SRC_A_PC;
                dec.src_b_sel = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.jal       = 1'b1;
                writes        = 1'b1;
            end
            is_jalr: begin
                dec.imm       = imm_i;
                dec.src_a_sel = SRC_A_PC;
                dec.src_b_sel = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.jalr      = 1'b1;
                writes        = 1'b1;
                bad           = (funct3 != 3'b000);
            end
            is_branch: begin
                dec.imm       = imm_b;
                dec.alu_op    = ALU_SUB;
                dec.branch    = 1'b1;
                dec.br_funct3 = funct3;
                bad           = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            is_load: begin
                dec.imm          = imm_i;
                dec.src_b_sel    = 1'b1;
                dec.alu_op       = ALU_ADD;
                dec.mem_rd       = 1'b1;
                dec.mem_size     = funct3[1:0];
                dec.mem_unsigned = funct3[2];
                writes           = 1'b1;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                      (funct3 == 3'b111);
            end
            is_store: begin
                dec.imm       = imm_s;
                dec.src_b_sel = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.mem_wr    = 1'b1;
                dec.mem_size  = funct3[1:0];
                bad           = funct3[2] || (funct3[1:0] == 2'b11);
            end
            is_opimm: begin
                dec.imm       = imm_i;
                dec.src_b_sel = 1'b1;
                writes        = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_ADD;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b110:  dec.alu_op = ALU_OR;
                    3'b111:  dec.alu_op = ALU_AND;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        bad        = !f7_zero;
                    end
                    default: begin
                        dec.alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                        bad        = !(f7_zero || f7_alt);
                    end
                endcase
            end
            is_op: begin
                writes = 1'b1;
                bad    = !f7_zero;
                case (funct3)
                    3'b000: begin
                        dec.alu_op = f7_alt ? ALU_SUB : ALU_ADD;
                        bad        = !(f7_zero || f7_alt);
                    end
                    3'b001:  dec.alu_op = ALU_SLL;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b101: begin
                        dec.alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                        bad        = !(f7_zero || f7_alt);
                    end
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            is_misc: begin
                dec.fence = 1'b1;
            end
            is_system: begin
                dec.ecall  = (instr == 32'h0000_0073);
                dec.ebreak = (instr == 32'h0010_0073);
                bad        = !(dec.ecall || dec.ebreak);
            end
            default: bad = 1'b1;
        endcase

        if (instr[1:0] != 2'b11)
            bad = 1'b1;

        dec.illegal = bad;
        dec.rd_we   = writes && !bad && (dec.rd != 5'd0);
        // Illegal words still flow downstream but must have no side effects
        if (bad) begin
            dec.mem_rd = 1'b0;
            dec.mem_wr = 1'b0;
            dec.branch = 1'b0;
            dec.jal    = 1'b0;
            dec.jalr   = 1'b0;
            dec.fence  = 1'b0;
            dec.ecall  = 1'b0;
            dec.ebreak = 1'b0;
        end
    end

    assign o_stall_to_if = i_stall & ~i_flush;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            o_dec_valid <= 1'b0;
            o_uop       <= '0;
            o_dec_pc    <= '0;
        end else if (i_flush) begin
            o_dec_valid <= 1'b0;
        end else if (!i_stall) begin
            o_dec_valid <= i_if_valid;
            if (i_if_valid) begin
                o_uop    <= dec;
                o_dec_pc <= i_if_pc;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-decoded RV32I words plus
// stall, flush and reset sequencing.

module tb_decode_stage;
    import riscv_uop_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_if_valid;
    logic [31:0] i_if_pc;
    logic [31:0] i_if_instr;
    logic        i_stall;
    logic        i_flush;
    logic        o_dec_valid;
    uop_t        o_uop;
    logic [31:0] o_dec_pc;
    logic        o_stall_to_if;

    int n_checks = 0;
    int n_pass   = 0;

    uop_t exp_u;
    uop_t held_u;

    decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_if_valid   (i_if_valid),
        .i_if_pc      (i_if_pc),
        .i_if_instr   (i_if_instr),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .o_dec_valid  (o_dec_valid),
        .o_uop        (o_uop),
        .o_dec_pc     (o_dec_pc),
        .o_stall_to_if(o_stall_to_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] got,
                         input logic [69:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic st,
                         input logic fl);
        i_if_valid = v;
        i_if_pc    = pc;
        i_if_instr = ins;
        i_stall    = st;
        i_flush    = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b1, 32'h44, 32'h0050_0093, 1'b0, 1'b0);
        tick;
        tick;
        check("reset_valid", 70'(o_dec_valid), 70'(0));
        check("reset_uop", o_uop, 70'(0));
        check("reset_pc", 70'(o_dec_pc), 70'(0));
        rst_n = 1'b0;

        // addi x1,x0,5
        drive(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
        tick;
        exp_u = '0;
        exp_u.rd = 5'd1; exp_u.rs2 = 5'd5; exp_u.imm = 32'd5;
        exp_u.alu_op = ALU_ADD; exp_u.src_b_sel = 1'b1;
        exp_u.rd_we = 1'b1;
        check("addi_valid", 70'(o_dec_valid), 70'(1));
        check("addi_uop", o_uop, exp_u);
        check("addi_pc", 70'(o_dec_pc), 70'(32'h100));

        // sw x2,8(x1)
        drive(1'b1, 32'h104, 32'h0020_A423, 1'b0, 1'b0);
        tick;
        exp_u = '0;
        exp_u.rd = 5'd8; exp_u.rs1 = 5'd1; exp_u.rs2 = 5'd2;
        exp_u.imm = 32'd8; exp_u.src_b_sel = 1'b1;
        exp_u.mem_wr = 1'b1; exp_u.mem_size = 2'd2;
        check("sw_uop", o_uop, exp_u);

        // beq x0,x0,-4
        drive(1'b1, 32'h108, 32'hFE00_0EE3, 1'b0, 1'b0);
        tick;
        check("beq_branch", 70'(o_uop.branch), 70'(1));
        check("beq_f3", 70'(o_uop.br_funct3), 70'(0));
        check("beq_imm", 70'(o_uop.imm), 70'(32'hFFFF_FFFC));
        check("beq_rdwe", 70'(o_uop.rd_we), 70'(0));

        // lui x5,0x12345
        drive(1'b1, 32'h10C, 32'h1234_52B7, 1'b0, 1'b0);
        tick;
        check("lui_imm", 70'(o_uop.imm), 70'(32'h1234_5000));
        check("lui_rd", 70'(o_uop.rd), 70'(5));
        check("lui_alu", 70'(o_uop.alu_op), 70'(ALU_PASS_B));
        check("lui_rdwe", 70'(o_uop.rd_we), 70'(1));

        // lhu x1,0(x1)
        drive(1'b1, 32'h110, 32'h0000_D083, 1'b0, 1'b0);
        tick;
        check("lhu_flags",
              70'({o_uop.mem_rd, o_uop.mem_size, o_uop.mem_unsigned}),
              70'(4'b1011));

        // sub x0,x1,x2: legal but rd=x0 so no write
        drive(1'b1, 32'h114, 32'h4020_8033, 1'b0, 1'b0);
        tick;
        check("sub_alu", 70'(o_uop.alu_op), 70'(ALU_SUB));
        check("sub_rdwe_illegal",
              70'({o_uop.rd_we, o_uop.illegal}), 70'(2'b00));

        // sll with funct7=0100000 is illegal
        drive(1'b1, 32'h118, 32'h4020_9033, 1'b0, 1'b0);
        tick;
        check("sll_alt_illegal", 70'(o_uop.illegal), 70'(1));

        drive(1'b1, 32'h11C, 32'h0000_0073, 1'b0, 1'b0);
        tick;
        check("ecall", 70'({o_uop.ecall, o_uop.ebreak, o_uop.illegal}),
              70'(3'b100));

        // all-ones word
        drive(1'b1, 32'h120, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick;
        check("ill_valid", 70'(o_dec_valid), 70'(1));
        check("ill_flag", 70'(o_uop.illegal), 70'(1));
        check("ill_ctl", 70'({o_uop.rd_we, o_uop.mem_rd, o_uop.mem_wr,
                               o_uop.branch, o_uop.jal, o_uop.jalr,
                               o_uop.fence, o_uop.ecall, o_uop.ebreak}),
              70'(0));

        // valid-low bubble: valid drops, uop/pc keep last load
        drive(1'b0, 32'h200, 32'h0050_0093, 1'b0, 1'b0);
        tick;
        check("bubble_valid", 70'(o_dec_valid), 70'(0));
        check("bubble_pc", 70'(o_dec_pc), 70'(32'h120));

        drive(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
        tick;
        held_u = '0;
        held_u.rd = 5'd1; held_u.rs2 = 5'd5; held_u.imm = 32'd5;
        held_u.src_b_sel = 1'b1; held_u.rd_we = 1'b1;

        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h300 + 32'(4 * k), 32'h1234_52B7, 1'b1, 1'b0);
            #1;
            check("stall_to_if", 70'(o_stall_to_if), 70'(1));
            tick;
            check("stall_valid", 70'(o_dec_valid), 70'(1));
            check("stall_uop", o_uop, held_u);
            check("stall_pc", 70'(o_dec_pc), 70'(32'h100));
        end

        drive(1'b1, 32'h400, 32'h1234_52B7, 1'b1, 1'b1);
        #1;
        check("flush_stall_to_if", 70'(o_stall_to_if), 70'(0));
        tick;
        check("flush_valid", 70'(o_dec_valid), 70'(0));

        // reset asserted while stalled with a valid micro-op held
        drive(1'b1, 32'h500, 32'h0020_A423, 1'b0, 1'b0);
        tick;
        check("pre_rst_valid", 70'(o_dec_valid), 70'(1));
        rst_n = 1'b1;
        drive(1'b1, 32'h504, 32'h0050_0093, 1'b1, 1'b0);
        tick;
        check("rst_valid", 70'(o_dec_valid), 70'(0));
        check("rst_uop", o_uop, 70'(0));
        check("rst_pc", 70'(o_dec_pc), 70'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
- REQ-001: The module SHALL have no parameters; XLEN is fixed at 32.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  reset; synchronous and active-high (asserted when 1).
- REQ-004: i_if_valid  input  1  fetch stage presents a valid instruction this cycle.
- REQ-005: i_if_pc  input  32  PC of the presented instruction.
- REQ-006: i_if_instr  input  32  RV32I instruction word.
- REQ-007: i_stall  input  1  downstream stall; hold all outputs.
- REQ-008: i_flush  input  1  squash the current and incoming instruction.
- REQ-009: o_dec_valid  output  1  o_uop/o_dec_pc carry a decoded instruction.
- REQ-010: o_uop  output  uop_t  registered decoded micro-op, packed struct in riscv_uop_pkg, fields MSB to LSB: rd[4:0], rs1[4:0], rs2[4:0], imm[31:0], alu_op[3:0], src_a_sel[1:0] (0 rs1, 1 pc, 2 zero), src_b_sel (0 rs2, 1 imm), rd_we, mem_rd, mem_wr, mem_size[1:0] (0 byte, 1 half, 2 word), mem_unsigned, branch, br_funct3[2:0], jal, jalr, fence, ecall, ebreak, illegal.
- REQ-011: o_dec_pc  output  32  PC of the instruction in o_uop.
- REQ-012: o_stall_to_if  output  1  combinational backpressure to fetch.

Function
- REQ-013: Decode SHALL be combinational from i_if_instr; results SHALL be registered, giving one-cycle latency from i_if_valid to o_dec_valid.
- REQ-014: Register update priority: rst_n > i_flush > i_stall > load.
- REQ-015: i_flush=1 SHALL set o_dec_valid=0 next cycle, ignore i_if_valid, and override i_stall; o_uop/o_dec_pc may retain old values.
- REQ-016: i_stall=1 (no flush) SHALL hold o_dec_valid, o_uop, o_dec_pc unchanged.
- REQ-017: Otherwise o_dec_valid <= i_if_valid; o_uop/o_dec_pc load only when i_if_valid=1.
- REQ-018: o_stall_to_if SHALL equal i_stall & ~i_flush, combinationally.
- REQ-019: Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, MISC-MEM 0001111, SYSTEM 1110011; any other opcode, or instr[1:0]!=2'b11, SHALL set illegal=1.
- REQ-020: Immediates SHALL be sign-extended to 32 bits per I/S/B/U/J formats; B/J immediates have bit0=0; U immediate = instr[31:12]<<12; R-type imm=0.
- REQ-021: alu_op encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- REQ-022: LUI: src_b=imm, alu PASS_B. AUIPC: src_a=pc, src_b=imm, ADD. JAL/JALR: rd_we per REQ-025, src_a=pc, imm target offset, jal/jalr flag set, alu ADD.
- REQ-023: OP funct7 must be 0000000 (or 0100000 only for ADD->SUB, SRL->SRA), OP-IMM shifts need imm[11:5] 0000000 (0100000 for SRAI); else illegal.
- REQ-024: LOAD funct3 in {000,001,010,100,101}, STORE in {000,001,010}, BRANCH excluding {010,011}, JALR funct3=000; violations illegal. mem_unsigned=funct3[2] for loads.
- REQ-025: rd_we=1 only for LUI, AUIPC, JAL, JALR, LOAD, OP, OP-IMM with rd!=0 and illegal=0.
- REQ-026: MISC-MEM SHALL set fence=1 (no other effect); SYSTEM 0x00000073 sets ecall, 0x00100073 ebreak; other SYSTEM words illegal.
- REQ-027: Illegal instructions SHALL still propagate with o_dec_valid=1 and rd_we=mem_rd=mem_wr=branch=jal=jalr=0.
- REQ-028: Unused register fields (e.g. rs2 for I-type) SHALL be the raw instruction bits; no hazard detection in this block.

Reset
- REQ-029: With rst_n=1 at a clock edge, o_dec_valid<=0, o_uop<=all zeros, o_dec_pc<=0; reset mid-stall or mid-flush SHALL behave identically.

Verification
- REQ-030: valid, instr 0x00500093 (addi x1,x0,5), pc 0x100 -> next cycle valid=1, rd=1, rs1=0, imm=5, alu ADD, src_b=imm, rd_we=1, o_dec_pc=0x100.
- REQ-031: instr 0x0020A423 (sw x2,8(x1)) -> rs1=1, rs2=2, imm=8, mem_wr=1, mem_size=2, rd_we=0.
- REQ-032: instr 0xFE000EE3 (beq x0,x0,-4) -> branch=1, br_funct3=0, imm=0xFFFFFFFC; instr 0x123452B7 (lui x5) -> imm=0x12345000, rd=5, PASS_B.
- REQ-033: instr 0xFFFFFFFF -> valid=1, illegal=1, all write/memory/control flags 0.
- REQ-034: i_stall=1 for 3 cycles with new instrs -> outputs frozen, o_stall_to_if=1; then i_flush=1 with i_stall=1 -> o_dec_valid=0 next cycle, o_stall_to_if=0.
- REQ-035: rst_n=1 asserted while o_dec_valid=1 -> next edge o_dec_valid=0, o_uop=0, o_dec_pc=0.
